// File: rtl/pixel_fifo_pkg.sv
// Shared defaults for the pixel line FIFO and its storage.
package pixel_fifo_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_AF_LEVEL = (1 << DEF_ADDR_W) - 16;

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port storage with a registered read port and no reset, so it maps onto block RAM.
module pixel_fifo_ram #(
   parameter int WIDTH  = 9,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pixel_line_fifo.sv
// Pixel line FIFO: RAM-backed queue of {eol, pixel} words with line counting, sticky
// error flags and an optional first-word-fall-through prefetch stage.
module pixel_line_fifo
   import pixel_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int SHOWAHEAD = 0,
   parameter int AF_LEVEL  = DEF_AF_LEVEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrreq,
   input  logic [DATA_W-1:0] data_in,
   input  logic              eol_in,
   input  logic              rdreq,
   input  logic              clr_err,
   output logic [DATA_W-1:0] data_out,
   output logic              eol_out,
   output logic              rdempty,
   output logic              wrfull,
   output logic              wralmost_full,
   output logic [ADDR_W:0]   usedw,
   output logic [ADDR_W:0]   lines_avail,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next, rd_addr;
   logic [ADDR_W:0]   usedw_q, usedw_next, mem_cnt, mem_cnt_next, lines_q, lines_next;
   logic              wrfull_q, af_q, rdempty_q, overflow_q, underflow_q;
   logic              pf_valid, pf_valid_next;
   logic              wr_accept, rd_accept, fetch, pop, line_in, line_out;
   logic [DATA_W:0]   ram_q, head, out_q, byp_data;
   logic              byp_valid;

   // The RAM always reads the word that will be at the read pointer after this edge,
   // so head is the oldest stored word; a same-edge write to that address is forwarded.
   pixel_fifo_ram #(
      .WIDTH  (DATA_W + 1),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr),
      .wr_data ({eol_in, data_in}),
      .rd_en   (1'b1),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   assign head = byp_valid ? byp_data : ram_q;

   always_comb begin
      wr_accept = wrreq && !wrfull_q && !rst;
      rd_accept = rdreq && !rdempty_q && !rst;
      // In show-ahead mode words leave the RAM into out_q ahead of being requested.
      fetch     = (mem_cnt != '0) && (!pf_valid || rd_accept) && !rst;
      pop       = (SHOWAHEAD != 0) ? fetch : rd_accept;

      rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
      rd_addr     = rst ? '0 : rd_ptr_next;

      usedw_next = usedw_q;
      if (wr_accept && !rd_accept)
         usedw_next = usedw_q + 1'b1;
      else if (rd_accept && !wr_accept)
         usedw_next = usedw_q - 1'b1;

      mem_cnt_next = mem_cnt;
      if (wr_accept && !pop)
         mem_cnt_next = mem_cnt + 1'b1;
      else if (pop && !wr_accept)
         mem_cnt_next = mem_cnt - 1'b1;

      line_in  = wr_accept && eol_in;
      line_out = rd_accept && ((SHOWAHEAD != 0) ? out_q[DATA_W] : head[DATA_W]);
      lines_next = lines_q;
      if (line_in && !line_out)
         lines_next = lines_q + 1'b1;
      else if (line_out && !line_in)
         lines_next = lines_q - 1'b1;

      pf_valid_next = 1'b0;
      if (SHOWAHEAD != 0) begin
         pf_valid_next = pf_valid;
         if (fetch)
            pf_valid_next = 1'b1;
         else if (rd_accept)
            pf_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         usedw_q     <= '0;
         mem_cnt     <= '0;
         lines_q     <= '0;
         wrfull_q    <= 1'b0;
         af_q        <= 1'b0;
         rdempty_q   <= 1'b1;
         pf_valid    <= 1'b0;
         out_q       <= '0;
         byp_valid   <= 1'b0;
         byp_data    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr    <= rd_ptr_next;
         usedw_q   <= usedw_next;
         mem_cnt   <= mem_cnt_next;
         lines_q   <= lines_next;
         wrfull_q  <= (usedw_next == FULL_CNT);
         af_q      <= (usedw_next >= AF_CNT);
         rdempty_q <= (SHOWAHEAD != 0) ? !pf_valid_next : (usedw_next == '0);
         pf_valid  <= pf_valid_next;
         if (pop) out_q <= head;
         byp_valid <= wr_accept && (wr_ptr == rd_addr);
         byp_data  <= {eol_in, data_in};

         // A fresh error in the same cycle as clr_err must survive the clear.
         if (wrreq && wrfull_q)
            overflow_q <= 1'b1;
         else if (clr_err)
            overflow_q <= 1'b0;
         if (rdreq && rdempty_q)
            underflow_q <= 1'b1;
         else if (clr_err)
            underflow_q <= 1'b0;
      end
   end

   assign data_out      = out_q[DATA_W-1:0];
   assign eol_out       = out_q[DATA_W];
   assign rdempty       = rdempty_q;
   assign wrfull        = wrfull_q;
   assign wralmost_full = af_q;
   assign usedw         = usedw_q;
   assign lines_avail   = lines_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule

// File: doc/pixel_line_fifo.md
PIXEL_LINE_FIFO -- requirements
Module: pixel_line_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel data width.
REQ-002 SHALL have parameter ADDR_W, default 10: depth = 2**ADDR_W words.
REQ-003 SHALL have parameter SHOWAHEAD, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_LEVEL, default 2**ADDR_W-16: almost-full threshold.
REQ-005 SHALL have one clock and a synchronous, active-high reset; the port lines are:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wrreq  in  1  write request.
- data_in  in  DATA_W  write data.
- eol_in  in  1  end-of-line tag stored with data_in.
- rdreq  in  1  read request.
- clr_err  in  1  clears sticky error flags.
- data_out  out  DATA_W  read data.
- eol_out  out  1  tag of data_out word.
- rdempty  out  1  no word readable.
- wrfull  out  1  2**ADDR_W words held.
- wralmost_full  out  1  usedw >= AF_LEVEL.
- usedw  out  ADDR_W+1  words held, 0..2**ADDR_W.
- lines_avail  out  ADDR_W+1  complete lines (eol-tagged words) held.
- overflow  out  1  sticky: write refused.
- underflow  out  1  sticky: read refused.

Function
REQ-006 Write accepted iff wrreq=1 and wrfull=1 was not asserted at the start of the cycle; {eol_in,data_in} stored at the write pointer; pointer increments, wrapping modulo 2**ADDR_W.
REQ-007 Read accepted iff rdreq=1 and rdempty=0; read pointer increments with wrap.
REQ-008 Simultaneous accepted read and write leave usedw unchanged; otherwise usedw +1 per write and -1 per read, registered.
REQ-009 wrfull is asserted the cycle after usedw reaches 2**ADDR_W; a read while full does not enable a same-cycle write.
REQ-010 SHOWAHEAD=0: data_out/eol_out update 1 cycle after an accepted read and hold otherwise; rdempty deasserts 1 cycle after the first write to an empty FIFO.
REQ-011 SHOWAHEAD=1: data_out/eol_out present the head word with no rdreq; rdempty deasserts exactly 2 cycles after the first write to an empty FIFO through a one-word prefetch register; an accepted read advances to the next word.
REQ-012 usedw and lines_avail include any word held in the prefetch register.
REQ-013 lines_avail: +1 on an accepted write with eol_in=1; -1 on an accepted read of a word with eol=1; unchanged when both happen in the same cycle.
REQ-014 overflow sets on wrreq=1 with wrfull=1; underflow sets on rdreq=1 with rdempty=1; a refused access changes no pointer, count or data_out.
REQ-015 clr_err clears both flags; a set condition in the same cycle wins.
REQ-016 wralmost_full is a registered comparison of the next usedw value.

Reset
REQ-017 With rst=1: pointers, usedw and lines_avail = 0; rdempty=1; wrfull=0; wralmost_full=0; overflow=underflow=0; data_out=0; eol_out=0; prefetch register invalid.
REQ-018 Reset during traffic discards all contents; wrreq/rdreq in the reset cycle are ignored; memory contents are not cleared.

Structure
REQ-019 Shared package pixel_fifo_pkg SHALL hold the default DATA_W, ADDR_W and AF_LEVEL values.
REQ-020 Storage SHALL be the sub-module pixel_fifo_ram: simple dual-port, width DATA_W+1, synchronous read, no reset, block-RAM inferable.
REQ-021 Pointers, counters, flags and the prefetch stage SHALL reside in pixel_line_fifo.

Verification
REQ-022 SHOWAHEAD=0: write 0x11,0x22,0x33,0x44 -> usedw=4; four reads -> data_out 0x11..0x44, each 1 cycle after its rdreq; rdempty=1 and usedw=0 afterwards.
REQ-023 Write 1024 words -> wrfull=1 and wralmost_full=1; an extra write of 0xAA -> dropped, overflow=1; read all 1024 -> no 0xAA appears.
REQ-024 At usedw=5, wrreq and rdreq together for 10 cycles -> usedw stays 5 and data order is preserved.
REQ-025 Write 640 words with eol_in=1 on the last word -> lines_avail=1; read 640 words -> eol_out=1 on the last word and lines_avail=0.
REQ-026 rdreq while empty -> underflow=1, data_out unchanged; then clr_err=1 -> underflow=0.
REQ-027 SHOWAHEAD=1: write 0x5A to an empty FIFO -> rdempty=0 two cycles later with data_out=0x5A and no rdreq; rst asserted with usedw=7 -> next cycle usedw=0 and rdempty=1.
